auto_gain_controller: RTL and testbench

- Closed-loop sequencer for the amplitude scaling stage: generates the 4-bit `amplitude_factor` that the scaler consumes.
- Observes the scaler's saturated 12-bit signed output over fixed windows of valid samples and steps the factor down on clipping/overshoot or up on undershoot, so the trace fills the screen without clipping.
- Sits between the waveform source/scaler and the display path.
- Falls back to a user-selected manual factor when auto mode is off.

---
 rtl/auto_gain_controller_if.sv | 21 ++
 rtl/auto_gain_controller.sv | 179 +++++++++++++++++
 tb/tb_auto_gain_controller.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/auto_gain_controller_if.sv
// Scaler-side bus of the auto gain controller: sample stream and mode select in, gain factor and window statistics out.
interface auto_gain_controller_if;
   logic               sample_valid;
   logic signed [11:0] wave_in;
   logic               auto_en;
   logic        [3:0]  manual_factor;
   logic        [3:0]  amplitude_factor;
   logic               factor_changed;
   logic               clip_flag;
   logic        [11:0] peak_out;

   modport master (
      output sample_valid, wave_in, auto_en, manual_factor,
      input  amplitude_factor, factor_changed, clip_flag, peak_out
   );

   modport slave (
      input  sample_valid, wave_in, auto_en, manual_factor,
      output amplitude_factor, factor_changed, clip_flag, peak_out
   );
endinterface

// File: rtl/auto_gain_controller.sv
// Windowed peak/clip tracker that steps amplitude_factor; new factor lands 2 cycles after the last window sample.
// No backpressure (samples taken whenever sample_valid); AGC_FAST_ATTACK_EN makes a clipped sample end the window early.
module auto_gain_controller #(
   parameter int WIN_LEN     = 4096,
   parameter int SETTLE_LEN  = 16,
   parameter int HI_THRESH   = 1900,
   parameter int LO_THRESH   = 900,
   parameter int MIN_FACTOR  = 1,
   parameter int MAX_FACTOR  = 15,
   parameter int INIT_FACTOR = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   auto_gain_controller_if.slave  bus
);
   localparam int               CNT_W       = $clog2(WIN_LEN);
   localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(WIN_LEN - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_LEN - 1);
   localparam logic [11:0]      HI_LIM      = 12'(HI_THRESH);
   localparam logic [11:0]      LO_LIM      = 12'(LO_THRESH);
   localparam logic [3:0]       MIN_F       = 4'(MIN_FACTOR);
   localparam logic [3:0]       MAX_F       = 4'(MAX_FACTOR);
   localparam logic [3:0]       INIT_F      = 4'(INIT_FACTOR);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      DECIDE  = 2'd2,
      SETTLE  = 2'd3
   } state_t;

   state_t           state_q,     state_d;
   logic [3:0]       factor_q,    factor_d;
   logic             changed_q,   changed_d;
   logic             clip_flag_q, clip_flag_d;
   logic [11:0]      peak_out_q,  peak_out_d;
   logic [11:0]      peak_acc_q,  peak_acc_d;
   logic             clip_acc_q,  clip_acc_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;

   logic [11:0]      mag;
   logic             sample_clip;
   logic             fast_trip;
   logic [3:0]       base_factor;
   logic [3:0]       next_factor;

   // Two's-complement negate keeps -2048 as 0x800, i.e. 2048 unsigned.
   always_comb begin
      mag         = bus.wave_in[11] ? (~bus.wave_in + 12'd1) : bus.wave_in;
      sample_clip = ($unsigned(bus.wave_in) == 12'h7FF) || ($unsigned(bus.wave_in) == 12'h800);
   end

`ifdef AGC_FAST_ATTACK_EN
   assign fast_trip = sample_clip;
`else
   assign fast_trip = 1'b0;
`endif

   // A manual factor carried in from IDLE is pulled into range before the step is applied.
   always_comb begin
      if (factor_q < MIN_F) begin
         base_factor = MIN_F;
      end else if (factor_q > MAX_F) begin
         base_factor = MAX_F;
      end else begin
         base_factor = factor_q;
      end

      next_factor = base_factor;
      if (clip_acc_q || (peak_acc_q > HI_LIM)) begin
         if (base_factor > MIN_F) begin
            next_factor = base_factor - 4'd1;
         end
      end else if (peak_acc_q < LO_LIM) begin
         if (base_factor < MAX_F) begin
            next_factor = base_factor + 4'd1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      factor_d    = factor_q;
      changed_d   = 1'b0;
      clip_flag_d = clip_flag_q;
      peak_out_d  = peak_out_q;
      peak_acc_d  = peak_acc_q;
      clip_acc_d  = clip_acc_q;
      cnt_d       = cnt_q;

      case (state_q)
         IDLE: begin
            factor_d   = bus.manual_factor;
            peak_acc_d = '0;
            clip_acc_d = 1'b0;
            cnt_d      = '0;
            if (bus.auto_en) begin
               state_d = MEASURE;
            end
         end

         MEASURE: begin
            if (bus.sample_valid) begin
               peak_acc_d = (mag > peak_acc_q) ? mag : peak_acc_q;
               clip_acc_d = clip_acc_q | sample_clip;
               cnt_d      = cnt_q + 1'b1;
               if ((cnt_q == WIN_LAST) || fast_trip) begin
                  state_d = DECIDE;
               end
            end
         end

         DECIDE: begin
            peak_out_d  = peak_acc_q;
            clip_flag_d = clip_acc_q;
            factor_d    = next_factor;
            changed_d   = (next_factor != factor_q);
            peak_acc_d  = '0;
            clip_acc_d  = 1'b0;
            cnt_d       = '0;
            state_d     = (next_factor != factor_q) ? SETTLE : MEASURE;
         end

         SETTLE: begin
            if (bus.sample_valid) begin
               if (cnt_q == SETTLE_LAST) begin
                  cnt_d   = '0;
                  state_d = MEASURE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Leaving auto mode drops the partial window but keeps the last reported statistics.
      if ((state_q != IDLE) && !bus.auto_en) begin
         state_d     = IDLE;
         factor_d    = bus.manual_factor;
         changed_d   = 1'b0;
         clip_flag_d = clip_flag_q;
         peak_out_d  = peak_out_q;
         peak_acc_d  = '0;
         clip_acc_d  = 1'b0;
         cnt_d       = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         factor_q    <= INIT_F;
         changed_q   <= 1'b0;
         clip_flag_q <= 1'b0;
         peak_out_q  <= '0;
         peak_acc_q  <= '0;
         clip_acc_q  <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         factor_q    <= factor_d;
         changed_q   <= changed_d;
         clip_flag_q <= clip_flag_d;
         peak_out_q  <= peak_out_d;
         peak_acc_q  <= peak_acc_d;
         clip_acc_q  <= clip_acc_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.amplitude_factor = factor_q;
   assign bus.factor_changed   = changed_q;
   assign bus.clip_flag        = clip_flag_q;
   assign bus.peak_out         = peak_out_q;
endmodule

// File: tb/tb_auto_gain_controller.sv
// Randomized bench for auto_gain_controller against a window-level reference model (WIN_LEN=64).
module tb_auto_gain_controller;
   localparam int WIN   = 64;
   localparam int SET   = 16;
   localparam int HI    = 1900;
   localparam int LO    = 900;
   localparam int MINF  = 1;
   localparam int MAXF  = 15;
   localparam int INITF = 8;
`ifdef AGC_FAST_ATTACK_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic clk;
   logic rst;

   auto_gain_controller_if agc_if ();

   auto_gain_controller #(
      .WIN_LEN     (WIN),
      .SETTLE_LEN  (SET),
      .HI_THRESH   (HI),
      .LO_THRESH   (LO),
      .MIN_FACTOR  (MINF),
      .MAX_FACTOR  (MAXF),
      .INIT_FACTOR (INITF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (agc_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: expected outputs after the next clock edge.
   int m_factor;
   bit m_chg;
   bit m_clip;
   int m_peak;
   bit m_auto;
   bit m_pending;
   int m_settle;
   int win_q[$];
   int amp_cls = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int mag_of(input int s);
      return (s < 0) ? -s : s;
   endfunction

   function automatic bit is_clip(input int s);
      return (s == 2047) || (s == -2048);
   endfunction

   task automatic model_step(input bit r, input bit ae, input int mf, input bit sv, input int w);
      int pk;
      bit cl;
      int base;
      int nf;
      m_chg = 1'b0;
      if (r) begin
         m_factor  = INITF;
         m_clip    = 1'b0;
         m_peak    = 0;
         m_auto    = 1'b0;
         m_pending = 1'b0;
         m_settle  = 0;
         win_q.delete();
      end else if (!m_auto) begin
         m_factor = mf;
         if (ae) begin
            m_auto    = 1'b1;
            m_pending = 1'b0;
            m_settle  = 0;
            win_q.delete();
         end
      end else if (!ae) begin
         m_auto    = 1'b0;
         m_factor  = mf;
         m_pending = 1'b0;
         m_settle  = 0;
         win_q.delete();
      end else if (m_pending) begin
         pk = 0;
         cl = 1'b0;
         foreach (win_q[i]) begin
            if (mag_of(win_q[i]) > pk) pk = mag_of(win_q[i]);
            if (is_clip(win_q[i])) cl = 1'b1;
         end
         base = (m_factor < MINF) ? MINF : ((m_factor > MAXF) ? MAXF : m_factor);
         nf   = base;
         if (cl || pk > HI) begin
            if (base > MINF) nf = base - 1;
         end else if (pk < LO) begin
            if (base < MAXF) nf = base + 1;
         end
         m_peak    = pk;
         m_clip    = cl;
         m_chg     = (nf != m_factor);
         m_settle  = m_chg ? SET : 0;
         m_factor  = nf;
         m_pending = 1'b0;
         win_q.delete();
      end else if (sv) begin
         if (m_settle > 0) begin
            m_settle--;
         end else begin
            win_q.push_back(w);
            if (win_q.size() == WIN || (FAST && is_clip(w))) m_pending = 1'b1;
         end
      end
   endtask

   // Modes: 0 reset, 1 manual, 2 full-scale clip, 3 low (+/-500), 4 mid with rare -2048,
   // 5 mixed amplitude with auto_en drops, 6 in-band (+/-1500).
   function automatic int gen_wave(input int mode);
      case (mode)
         2: return 2047;
         3: return int'($urandom_range(0, 1000)) - 500;
         4: return ($urandom_range(0, 199) == 0) ? -2048 : int'($urandom_range(0, 2400)) - 1200;
         6: return int'($urandom_range(0, 3000)) - 1500;
         5: begin
            if ($urandom_range(0, 99) == 0) amp_cls = int'($urandom_range(0, 3));
            case (amp_cls)
               0:       return int'($urandom_range(0, 800)) - 400;
               1:       return int'($urandom_range(0, 3000)) - 1500;
               2:       return int'($urandom_range(0, 4095)) - 2048;
               default: return int'($urandom_range(0, 4000)) - 2000;
            endcase
         end
         default: return int'($urandom_range(0, 4095)) - 2048;
      endcase
   endfunction

   task automatic run(input int n, input int mode, input int man);
      bit r;
      bit ae;
      bit sv;
      int mf;
      int w;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("amplitude_factor", int'(agc_if.amplitude_factor), m_factor);
         check("factor_changed",   int'(agc_if.factor_changed),   int'(m_chg));
         check("clip_flag",        int'(agc_if.clip_flag),        int'(m_clip));
         check("peak_out",         int'(agc_if.peak_out),         m_peak);
         r  = (mode == 0);
         mf = (man < 0) ? int'($urandom_range(0, 15)) : man;
         case (mode)
            1:       ae = 1'b0;
            5:       ae = ($urandom_range(0, 299) != 0);
            0:       ae = 1'(($urandom_range(0, 1)));
            default: ae = 1'b1;
         endcase
         sv = (mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
         w  = gen_wave(mode);
         rst                  = r;
         agc_if.auto_en       = ae;
         agc_if.manual_factor = 4'(mf);
         agc_if.sample_valid  = sv;
         agc_if.wave_in       = 12'(w);
         model_step(r, ae, mf, sv, w);
      end
   endtask

   initial begin
      rst                  = 1'b1;
      agc_if.auto_en       = 1'b0;
      agc_if.manual_factor = 4'd0;
      agc_if.sample_valid  = 1'b0;
      agc_if.wave_in       = '0;
      model_step(1'b1, 1'b0, 0, 1'b0, 0);

      run(3,    0, -1);
      run(20,   1,  5);
      run(300,  2, -1);
      run(5,    1,  0);
      run(1500, 3, -1);
      run(1200, 4, -1);
      run(1000, 6, -1);
      run(4000, 5, -1);
      run(2,    0, -1);
      run(3,    1, -1);
      run(2000, 2, -1);
      run(1200, 3, -1);
      run(5000, 5, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
